// File: rtl/uart_pkg.sv
// Shared UART definitions: reset divisor, oversample rate and the
// configuration FSM state encoding.
package uart_pkg;

  localparam logic [15:0] UART_DEFAULT_DIV = 16'd27;
  localparam int          UART_OS_RATE     = 16;

  typedef enum logic [1:0] {
    CFG_IDLE = 2'd0,
    CFG_WAIT = 2'd1,
    CFG_LOAD = 2'd2
  } cfg_state_t;

endpackage

// File: rtl/uart_tick_div.sv
// Shared baud divider: counts 1..Div while enabled and flags the cycle in
// which the count reaches Div (the oversample event).
module uart_tick_div
  import uart_pkg::*;
(
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        En,
  input  logic        Clr,
  input  logic [15:0] Div,
  output logic        Os_evt
);

  logic [15:0] cnt;
  logic        hit;

  assign hit = (cnt == Div);

  // Clear wins over counting so a realign never produces an event.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      cnt <= 16'd1;
    end else if (Clr) begin
      cnt <= 16'd1;
    end else if (En) begin
      cnt <= hit ? 16'd1 : cnt + 16'd1;
    end
  end

  assign Os_evt = En & ~Clr & hit;

endmodule

// File: rtl/uart_baud_ctrl.sv
// UART baud timing controller: owns the active divisor, produces the 16x
// oversample and 1x bit ticks, and applies divisor changes only when idle.
module uart_baud_ctrl
  import uart_pkg::*;
#(
  parameter logic [15:0] DEFAULT_DIV = UART_DEFAULT_DIV,
  parameter int          OS_RATE     = UART_OS_RATE
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        En,
  input  logic        Cfg_valid,
  input  logic [15:0] Cfg_divisor,
  output logic        Cfg_ready,
  output logic        Cfg_err,
  input  logic        Tx_busy,
  input  logic        Rx_busy,
  input  logic        Tx_start,
  output logic        Os_tick,
  output logic        Tx_tick,
  output logic [15:0] Divisor,
  output logic        Cfg_pending
);

  localparam logic [3:0] OS_LAST = 4'(OS_RATE - 1);

  cfg_state_t  state;
  cfg_state_t  next_state;
  logic [15:0] pend_div;
  logic [3:0]  os_cnt;
  logic        os_evt;
  logic        accept;
  logic        load;
  logic        clr;
  logic        err_d;

  assign accept = Cfg_valid & Cfg_ready;
  assign load   = (state == CFG_LOAD);
  assign clr    = Tx_start | load;

  uart_tick_div u_tick_div (
    .Clk    (Clk),
    .Rst_n  (Rst_n),
    .En     (En),
    .Clr    (clr),
    .Div    (Divisor),
    .Os_evt (os_evt)
  );

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state <= CFG_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    err_d      = 1'b0;
    case (state)
      CFG_IDLE: begin
        if (accept) begin
          if (Cfg_divisor == 16'd0) err_d = 1'b1;
          else                      next_state = CFG_WAIT;
        end
      end
      // Both engines must be idle in the same cycle before the swap.
      CFG_WAIT: begin
        if (!Tx_busy && !Rx_busy) next_state = CFG_LOAD;
      end
      CFG_LOAD: next_state = CFG_IDLE;
      default:  next_state = CFG_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      pend_div <= DEFAULT_DIV;
    end else if (state == CFG_IDLE && accept && Cfg_divisor != 16'd0) begin
      pend_div <= Cfg_divisor;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n)    Divisor <= DEFAULT_DIV;
    else if (load) Divisor <= pend_div;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n)      os_cnt <= 4'd0;
    else if (clr)    os_cnt <= 4'd0;
    else if (os_evt) os_cnt <= os_cnt + 4'd1;
  end

  // Handshake flags follow the upcoming state so they stay low in reset.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      Os_tick     <= 1'b0;
      Tx_tick     <= 1'b0;
      Cfg_err     <= 1'b0;
      Cfg_ready   <= 1'b0;
      Cfg_pending <= 1'b0;
    end else begin
      Os_tick     <= os_evt;
      Tx_tick     <= os_evt && (os_cnt == OS_LAST);
      Cfg_err     <= err_d;
      Cfg_ready   <= (next_state == CFG_IDLE);
      Cfg_pending <= (next_state != CFG_IDLE);
    end
  end

endmodule

// File: doc/uart_baud_ctrl.md
# uart_baud_ctrl

Run-time controller for the UART baud timing path. It owns the active baud divisor and generates the 16x oversample tick for the receiver and the 1x bit tick for the transmitter from a single shared counter. It accepts divisor changes over a valid/ready configuration port and applies them only when both TX and RX are idle, so no frame is ever corrupted. It sits between the register/host interface and the UART TX/RX engines.

## Interface
- DEFAULT_DIV, 16'd27: divisor loaded at reset, in clocks per oversample tick (50 MHz / 115200 / 16).
- OS_RATE, 16: oversample ticks per bit. Fixed at 16; the phase counter is 4 bits.
- Clk  in  1  system clock
- Rst_n  in  1  reset, asynchronous, active-low
- En  in  1  tick generation enable; low holds counters and suppresses ticks
- Cfg_valid  in  1  new divisor offered
- Cfg_divisor  in  16  requested divisor; 0 is illegal
- Cfg_ready  out  1  controller can accept a divisor
- Cfg_err  out  1  one-cycle pulse when a divisor of 0 is offered
- Tx_busy  in  1  TX engine mid-frame
- Rx_busy  in  1  RX engine mid-frame
- Tx_start  in  1  one-cycle pulse that realigns bit phase at TX start-bit launch
- Os_tick  out  1  16x oversample tick, one cycle wide
- Tx_tick  out  1  bit tick, one cycle wide
- Divisor  out  16  currently active divisor
- Cfg_pending  out  1  a divisor is accepted but not yet applied

## Operation
- Divider: cnt[15:0], reset 1. When En=1, cnt increments each cycle. When cnt==Divisor, cnt returns to 1 and an oversample event fires. Os_tick period is exactly Divisor cycles; Divisor=1 gives Os_tick every cycle.
- Phase: os_cnt[3:0], reset 0. It increments on each oversample event. The event with os_cnt==15 also fires Tx_tick, and os_cnt wraps to 0.
- En=0: cnt and os_cnt hold their values. Os_tick and Tx_tick stay 0. The config FSM keeps running.
- Tx_start (any state, En ignored): sets cnt=1 and os_cnt=0. It has priority over a coincident oversample event; no tick fires in that cycle. The first Tx_tick follows exactly 16*Divisor enabled cycles later.
- Config FSM states:
  - CFG_IDLE: Cfg_ready=1. On Cfg_valid with Cfg_divisor==0: pulse Cfg_err, stay in CFG_IDLE. On Cfg_valid with a nonzero divisor: latch pend_div, go to CFG_WAIT.
  - CFG_WAIT: Cfg_ready=0, Cfg_pending=1. Ticks continue at the old Divisor. When Tx_busy=0 and Rx_busy=0 in the same cycle, go to CFG_LOAD.
  - CFG_LOAD, one cycle: Divisor<=pend_div, cnt<=1, os_cnt<=0, no tick this cycle, then go to CFG_IDLE.
- A Tx_start in the same cycle as CFG_LOAD is absorbed; the result is identical.
- Busy rising again during CFG_WAIT restarts the wait. Only a simultaneous idle of both engines triggers the load.

## Timing
- Reset values: Divisor=DEFAULT_DIV, cnt=1, os_cnt=0, state CFG_IDLE, Os_tick=0, Tx_tick=0, Cfg_ready=0 during reset and 1 from the first clock after release, Cfg_err=0, Cfg_pending=0.
- All outputs are registered. Os_tick and Tx_tick assert the cycle after cnt==Divisor is sampled.
- Cfg_ready is a function of registered state only, not combinational from Cfg_valid.
- Accept to apply latency: minimum 2 cycles (IDLE→WAIT, WAIT→LOAD with both engines idle). The new Divisor is visible on the following cycle.
- Cfg_err asserts 1 cycle after the offending handshake and lasts 1 cycle.
- Reset mid-CFG_WAIT discards pend_div; Divisor returns to DEFAULT_DIV.
- Width: cnt is 16 bit and never exceeds Divisor, because a load always resets cnt. There is no wrap beyond 16'hFFFF; Divisor=16'hFFFF gives a 65535-cycle period.

## Structure
- Shared package uart_pkg: UART_DEFAULT_DIV, UART_OS_RATE, and the cfg_state_t enum (CFG_IDLE, CFG_WAIT, CFG_LOAD).
- One sub-module: uart_tick_div. It holds the 16-bit divider with synchronous clear/load and enable, and outputs the oversample event.
- Phase counter, config FSM and output registers live in the top-level uart_baud_ctrl.

## Test plan
- Reset, En=1, no config: Os_tick every 27 cycles; Tx_tick every 432 cycles, coincident with every 16th Os_tick; Divisor=27.
- Cfg_divisor=4 with both busy low: accepted; Divisor=4 two cycles later; Os_tick every 4 cycles; first Tx_tick 64 cycles after load.
- Cfg_divisor=8 while Tx_busy=1: Cfg_pending=1 and ticks stay at 27 until Tx_busy falls; load then occurs, and Cfg_ready=0 throughout the wait.
- Cfg_divisor=0: one-cycle Cfg_err; Divisor unchanged; Cfg_ready stays 1.
- Tx_start asserted in the cycle an Os_tick is due: no tick that cycle; next Tx_tick exactly 16*Divisor cycles later.
- En low for 100 cycles mid-bit, then high: no ticks while low; tick phase resumes from the held cnt/os_cnt. Then assert Rst_n mid-CFG_WAIT: Divisor=27 and Cfg_pending=0.
